uart_rx: RTL

- Serial UART receiver, 8N1 framing, LSB first.
- Sits directly upstream of the UART receive FIFO.
- Deserialises the rx pin into bytes and presents each good byte on data_out with a one-cycle data_valid pulse. That pulse drives the FIFO's write_en; data_out drives the FIFO's data_in.
- Flags framing errors and overruns (byte arrived while the FIFO was full) for the controller.

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-in / byte-out signal bundle for the UART receiver
interface uart_rx_if;
    logic       rx;
    logic       fifo_full;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // master: the receiver itself; slave: the FIFO/controller side consuming its results
    modport master (
        input  rx,
        input  fifo_full,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output fifo_full,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver feeding the receive FIFO, with framing/overrun flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_sync1;
    logic             r_sync2;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       w_data_out_nxt;
    logic             w_data_valid_nxt;
    logic             w_frame_err_nxt;
    logic             w_overrun_nxt;
    logic             w_rx_s;

    // Synchronisers reset to 1 so the idle line is not mistaken for a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_overrun_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    // Leaving at mid stop bit lets a following start edge be caught with no idle gap
                    if (w_rx_s) begin
                        w_data_out_nxt   = r_shift;
                        w_data_valid_nxt = !bus.fifo_full;
                        w_overrun_nxt    = bus.fifo_full;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != S_IDLE);
endmodule
